// File: rtl/pipelined_bram_tree.sv
// Binary-heap priority queue with one block RAM per tree level and a top-down sift FSM.
// Define PIPELINED_BRAM_TREE_MIN_HEAP_EN to build a min-queue (root = minimum).
module bram_level #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned AW    = 1,
  parameter int unsigned DW    = 16
) (
  input  logic          CLK,
  input  logic [AW-1:0] rd_addr_a,
  input  logic [AW-1:0] rd_addr_b,
  output logic [DW-1:0] rd_data_a,
  output logic [DW-1:0] rd_data_b,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);
  logic [DW-1:0] ram [DEPTH];

  always_ff @(posedge CLK) begin
    rd_data_a <= ram[rd_addr_a];
    rd_data_b <= ram[rd_addr_b];
    if (wr_en) ram[wr_addr] <= wr_data;
  end
endmodule

module pipelined_bram_tree #(
  parameter int unsigned QUEUE_SIZE = 31,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RSTn,
  input  logic                  i_wrt,
  input  logic                  i_read,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_data
);
  localparam int unsigned LEVELS = $clog2(QUEUE_SIZE + 1);
  localparam int unsigned SW     = LEVELS;
  localparam int unsigned AW     = (LEVELS > 1) ? LEVELS - 1 : 1;
  localparam int unsigned LW     = $clog2(LEVELS + 1);
  localparam int unsigned IXW    = LEVELS + 1;
  localparam int unsigned DW     = DATA_WIDTH;

  typedef enum logic [2:0] {IDLE = 3'd0, LOAD, READ, COMPARE, WRITE, FINWR} state_t;
  state_t next_state, state_d;

  logic [SW-1:0]  next_queue_size;
  logic [LW-1:0]  cur_lvl, ld_lvl, last_lvl;
  logic [AW-1:0]  cur_addr, sel_addr, last_addr, child_addr;
  logic [DW-1:0]  carry, sel_val, child_a, child_b, child_val, ld_val;
  logic [AW-1:0]  rd_addr_a, rd_addr_b;
  logic [DW-1:0]  rd_a [LEVELS];
  logic [DW-1:0]  rd_b [LEVELS];
  logic           wr_en [LEVELS];
  logic [AW-1:0]  wr_addr [LEVELS];
  logic [DW-1:0]  wr_data [LEVELS];
  logic [IXW-1:0] lvl_base, left_idx;
  logic           has_left, has_right, use_right, do_swap;

  function automatic logic better(input logic [DW-1:0] a, input logic [DW-1:0] b);
`ifdef PIPELINED_BRAM_TREE_MIN_HEAP_EN
    return a < b;
`else
    return a > b;
`endif
  endfunction

  for (genvar g = 0; g < LEVELS; g++) begin : gen_bram
    localparam int unsigned LAW = (g > 0) ? g : 1;
    logic [LAW-1:0] ra, rb, wa;
    // Level 0 has a single slot, so its port A always returns the root.
    assign ra = (g > 0) ? rd_addr_a[LAW-1:0] : '0;
    assign rb = (g > 0) ? rd_addr_b[LAW-1:0] : '0;
    assign wa = wr_addr[g][LAW-1:0];
    bram_level #(.DEPTH(1 << g), .AW(LAW), .DW(DW)) bram_inst (
      .CLK      (CLK),
      .rd_addr_a(ra),
      .rd_addr_b(rb),
      .rd_data_a(rd_a[g]),
      .rd_data_b(rd_b[g]),
      .wr_en    (wr_en[g]),
      .wr_addr  (wa),
      .wr_data  (wr_data[g])
    );
  end

  always_comb begin
    last_lvl  = '0;
    last_addr = '0;
    child_a   = '0;
    child_b   = '0;
    ld_val    = '0;
    for (int unsigned j = 0; j < LEVELS; j++) begin
      if (IXW'(next_queue_size) >= (IXW'(1) << j)) begin
        last_lvl  = LW'(j);
        last_addr = AW'(IXW'(next_queue_size) - (IXW'(1) << j));
      end
      if (LW'(j) == cur_lvl + LW'(1)) begin
        child_a = rd_a[j];
        child_b = rd_b[j];
      end
      if (LW'(j) == ld_lvl) ld_val = rd_a[j];
    end
    lvl_base   = (IXW'(1) << (cur_lvl + LW'(1))) - IXW'(1);
    left_idx   = lvl_base + (IXW'(cur_addr) << 1);
    has_left   = (cur_lvl < LW'(LEVELS - 1)) && (left_idx < IXW'(next_queue_size));
    has_right  = (left_idx + IXW'(1)) < IXW'(next_queue_size);
    use_right  = has_right && better(child_b, child_a);
    child_val  = use_right ? child_b : child_a;
    child_addr = AW'({cur_addr, use_right});
    do_swap    = better(child_val, carry);
  end

  always_comb begin
    for (int unsigned j = 0; j < LEVELS; j++) begin
      wr_en[j]   = 1'b0;
      wr_addr[j] = '0;
      wr_data[j] = '0;
      if (next_state == WRITE && LW'(j) == cur_lvl) begin
        wr_en[j]   = 1'b1;
        wr_addr[j] = cur_addr;
        wr_data[j] = sel_val;
      end else if (next_state == WRITE && LW'(j) == cur_lvl + LW'(1)) begin
        wr_en[j]   = 1'b1;
        wr_addr[j] = sel_addr;
        wr_data[j] = carry;
      end else if (next_state == FINWR && LW'(j) == cur_lvl) begin
        wr_en[j]   = 1'b1;
        wr_addr[j] = cur_addr;
        wr_data[j] = carry;
      end
    end
  end

  always_comb begin
    state_d   = next_state;
    rd_addr_a = '0;
    rd_addr_b = '0;
    case (next_state)
      IDLE: begin
        rd_addr_a = last_addr;
        if (i_read && i_wrt) state_d = READ;
        else if (i_read && next_queue_size != '0) state_d = LOAD;
      end
      LOAD: state_d = READ;
      READ: begin
        if (has_left) begin
          rd_addr_a = AW'({cur_addr, 1'b0});
          rd_addr_b = AW'({cur_addr, 1'b1});
          state_d   = COMPARE;
        end else begin
          state_d = FINWR;
        end
      end
      COMPARE: state_d = do_swap ? WRITE : FINWR;
      WRITE:   state_d = READ;
      FINWR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) next_state <= IDLE;
    else       next_state <= state_d;
  end

  // Size is only assigned on commands so an externally written value persists.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      next_queue_size <= '0;
      cur_lvl         <= '0;
      cur_addr        <= '0;
      ld_lvl          <= '0;
      carry           <= '0;
      sel_val         <= '0;
      sel_addr        <= '0;
      o_data          <= '0;
      o_empty         <= 1'b1;
      o_full          <= 1'b0;
    end else begin
      o_empty <= (next_queue_size == '0);
      o_full  <= (next_queue_size == SW'(QUEUE_SIZE));
      if (next_queue_size == '0)  o_data <= '0;
      else if (next_state == IDLE) o_data <= rd_a[0];
      case (next_state)
        IDLE: begin
          cur_lvl  <= '0;
          cur_addr <= '0;
          if (i_read && i_wrt) begin
            carry <= i_data;
            if (next_queue_size == '0) next_queue_size <= SW'(1);
          end else if (i_read && next_queue_size != '0) begin
            ld_lvl          <= last_lvl;
            next_queue_size <= next_queue_size - SW'(1);
          end
        end
        LOAD: carry <= ld_val;
        COMPARE: begin
          sel_val  <= child_val;
          sel_addr <= child_addr;
        end
        WRITE: begin
          cur_lvl  <= cur_lvl + LW'(1);
          cur_addr <= sel_addr;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_pipelined_bram_tree.sv
// Scoreboard bench for pipelined_bram_tree: a software max-queue predicts o_data per command.
module tb_pipelined_bram_tree;
  localparam int DW = 16;

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          i_wrt = 1'b0;
  logic          i_read = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          o_full, o_empty;
  logic [DW-1:0] o_data;

  int total = 0;
  int bad = 0;
  int model[$];
  int exp_q[$];

  always #5 CLK = ~CLK;

  pipelined_bram_tree #(.QUEUE_SIZE(31), .DATA_WIDTH(DW)) dut (
    .CLK    (CLK),
    .RSTn   (RSTn),
    .i_wrt  (i_wrt),
    .i_read (i_read),
    .i_data (i_data),
    .o_full (o_full),
    .o_empty(o_empty),
    .o_data (o_data)
  );

  function automatic int model_max();
    int m = 0;
    foreach (model[i]) if (model[i] > m) m = model[i];
    return m;
  endfunction

  function automatic void model_pop_max();
    int idx = 0;
    foreach (model[i]) if (model[i] > model[idx]) idx = i;
    model.delete(idx);
  endfunction

  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    model.delete();
    exp_q.delete();
  endtask

  task automatic preload_full();
    for (int a = 0; a < 1; a++)  dut.gen_bram[0].bram_inst.ram[a] = DW'(1024 - a);
    for (int a = 0; a < 2; a++)  dut.gen_bram[1].bram_inst.ram[a] = DW'(1024 - (1 + a));
    for (int a = 0; a < 4; a++)  dut.gen_bram[2].bram_inst.ram[a] = DW'(1024 - (3 + a));
    for (int a = 0; a < 8; a++)  dut.gen_bram[3].bram_inst.ram[a] = DW'(1024 - (7 + a));
    for (int a = 0; a < 16; a++) dut.gen_bram[4].bram_inst.ram[a] = DW'(1024 - (15 + a));
    dut.next_queue_size = 5'd31;
    model.delete();
    for (int n = 0; n < 31; n++) model.push_back(1024 - n);
    repeat (16) @(negedge CLK);
  endtask

  task automatic issue(input logic rd, input logic wr, input int v);
    if (rd && wr) begin
      if (model.size() > 0) model_pop_max();
      model.push_back(v);
    end else if (rd && !wr && model.size() > 0) begin
      model_pop_max();
    end
    exp_q.push_back(model_max());
    @(negedge CLK);
    i_read = rd;
    i_wrt  = wr;
    i_data = DW'(v);
    @(negedge CLK);
    i_read = 1'b0;
    i_wrt  = 1'b0;
    repeat (24) @(negedge CLK);
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", o_empty); end
    total++; if (o_full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", o_full); end
    total++; if (o_data !== '0) begin bad++; $display("FAIL reset_data got=%0d want=0", o_data); end
  endtask

  task automatic test_preload();
    preload_full();
    total++; if (o_data !== DW'(1024)) begin bad++; $display("FAIL preload_data got=%0d want=1024", o_data); end
    total++; if (o_full !== 1'b1) begin bad++; $display("FAIL preload_full got=%b want=1", o_full); end
    total++; if (o_empty !== 1'b0) begin bad++; $display("FAIL preload_empty got=%b want=0", o_empty); end
  endtask

  task automatic test_dequeue_all();
    int e;
    for (int k = 0; k < 31; k++) begin
      issue(1'b1, 1'b0, 0);
      e = exp_q.pop_front();
      total++;
      if (o_data !== DW'(e)) begin bad++; $display("FAIL deq%0d_data got=%0d want=%0d", k, o_data, e); end
      if (k == 0) begin
        total++; if (o_full !== 1'b0) begin bad++; $display("FAIL deq0_full got=%b want=0", o_full); end
      end
    end
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL drained_empty got=%b want=1", o_empty); end
    total++; if (o_data !== '0) begin bad++; $display("FAIL drained_data got=%0d want=0", o_data); end
    issue(1'b1, 1'b0, 0);
    e = exp_q.pop_front();
    total++; if (o_data !== DW'(e)) begin bad++; $display("FAIL deq_empty_data got=%0d want=%0d", o_data, e); end
    total++; if (o_empty !== 1'b1) begin bad++; $display("FAIL deq_empty_empty got=%b want=1", o_empty); end
  endtask

  task automatic test_replace_small();
    int e;
    do_reset();
    preload_full();
    issue(1'b1, 1'b1, 5);
    e = exp_q.pop_front();
    total++; if (o_data !== DW'(e)) begin bad++; $display("FAIL repl5_data got=%0d want=%0d", o_data, e); end
    total++; if (o_full !== 1'b1) begin bad++; $display("FAIL repl5_full got=%b want=1", o_full); end
    total++;
    if (dut.gen_bram[4].bram_inst.ram[0] !== DW'(5)) begin
      bad++; $display("FAIL repl5_leaf got=%0d want=5", dut.gen_bram[4].bram_inst.ram[0]);
    end
  endtask

  task automatic test_replace_large();
    int e;
    do_reset();
    preload_full();
    issue(1'b1, 1'b1, 1025);
    e = exp_q.pop_front();
    total++; if (o_data !== DW'(e)) begin bad++; $display("FAIL repl1025_data got=%0d want=%0d", o_data, e); end
    total++;
    if (dut.gen_bram[1].bram_inst.ram[0] !== DW'(1023)) begin
      bad++; $display("FAIL repl1025_l1a got=%0d want=1023", dut.gen_bram[1].bram_inst.ram[0]);
    end
    total++;
    if (dut.gen_bram[1].bram_inst.ram[1] !== DW'(1022)) begin
      bad++; $display("FAIL repl1025_l1b got=%0d want=1022", dut.gen_bram[1].bram_inst.ram[1]);
    end
    issue(1'b0, 1'b1, 2000);
    e = exp_q.pop_front();
    total++; if (o_data !== DW'(e)) begin bad++; $display("FAIL wrt_only_data got=%0d want=%0d", o_data, e); end
  endtask

  task automatic test_random();
    int e;
    logic wr;
    int v;
    do_reset();
    preload_full();
    for (int k = 0; k < 100; k++) begin
      wr = 1'($urandom_range(0, 1));
      v  = int'($urandom_range(0, 1024));
      issue(1'b1, wr, v);
      e = exp_q.pop_front();
      total++;
      if (o_data !== DW'(e)) begin bad++; $display("FAIL rnd%0d_data got=%0d want=%0d", k, o_data, e); end
      total++;
      if (o_empty !== (model.size() == 0)) begin
        bad++; $display("FAIL rnd%0d_empty got=%b want=%b", k, o_empty, model.size() == 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_dequeue_all();
    test_replace_small();
    test_replace_large();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipelined_bram_tree.md
Name: pipelined_bram_tree

Overview:
Max-priority queue built as a binary heap whose levels are stored in separate per-level block RAMs. The root (maximum) is always presented on o_data. Dequeue and replace-root operations are resolved by a top-down sift, one level at a time, driven by a control FSM. It sits as a sorting/scheduling primitive for hardware priority-queue users.

Parameters:
QUEUE_SIZE, 31, maximum element count; tree has LEVELS = clog2(QUEUE_SIZE+1) levels (5 by default).
DATA_WIDTH, 16, width of each element and of i_data/o_data.

Ports:
CLK  input  1  single clock, rising edge.
RSTn  input  1  asynchronous active-low reset.
i_wrt  input  1  write strobe (used with i_read for replace).
i_read  input  1  read strobe (dequeue, or replace when i_wrt also high).
i_data  input  DATA_WIDTH  value inserted by replace.
o_full  output  1  high when size == QUEUE_SIZE.
o_empty  output  1  high when size == 0.
o_data  output  DATA_WIDTH  current maximum (root); 0 when empty.

Behaviour:
- Storage: node n (0-based breadth-first order) lives at level L = floor(log2(n+1)), address n-(2^L-1), in instance gen_bram[L].bram_inst, array ram (depth 2^L, DATA_WIDTH wide, 1-cycle read latency, no reset of contents). Hierarchy names gen_bram[L].bram_inst.ram, next_queue_size and next_state are fixed so benches can preload a valid heap and set the size directly; next_state = 0 encodes IDLE.
- Heap invariant: every parent >= each existing child; nodes with index >= size are absent and never compared.
- Reset: size 0, FSM IDLE, o_data 0, o_empty 1, o_full 0.
- Commands sampled only in IDLE, one-cycle pulses:
  - i_read & !i_wrt & !o_empty: dequeue. Last element (index size-1) moves to the root, size decrements, sift-down begins.
  - i_read & i_wrt: replace. i_data overwrites the root, size unchanged, sift-down begins. Legal when empty: the value becomes the single element, size 1.
  - i_read & !i_wrt while empty: ignored.
  - i_wrt & !i_read: ignored (no standalone enqueue); o_full is informational.
- Sift-down per level L (3 cycles):
  - READ: issue reads of both children at level L+1 (addresses 2k, 2k+1).
  - COMPARE: pick the larger existing child; if it exceeds the carried value, swap.
  - WRITE: parent slot gets the child value, child slot gets the carried value; continue at L+1. Otherwise write the carried value at level L and finish.
  - Reaching the last level or an absent child ends the sift.
- Latency: the whole operation, including the root refresh, completes within 24 cycles of the command edge. The bench waits 24 cycles between commands. Commands arriving while not IDLE are ignored.
- o_data: register refreshed from gen_bram[0] address 0 every IDLE cycle, so externally preloaded contents appear within 2 cycles. Forced to 0 whenever size == 0.
- o_empty/o_full: registered from size, valid by the time the FSM returns to IDLE.
- Ties: either child may be chosen; the result must still satisfy the invariant.
- Reset mid-operation returns to the reset state; RAM contents are undefined.

Optional Feature:
PIPELINED_BRAM_TREE_MIN_HEAP_EN: when defined, all comparisons invert and the block is a min-queue (root = minimum). When undefined, it is a max-queue as described.

Test Plan:
- Reset: RSTn low for 1 cycle -> o_empty=1, o_full=0, o_data=0.
- Preload a sorted-descending heap of 31 values (e.g. 1024..994), next_queue_size=31, next_state=0, wait 16 cycles -> o_data=1024, o_full=1, o_empty=0.
- 31 dequeues spaced 25 cycles apart -> after each, o_data equals the next largest remaining value. After the 31st: o_empty=1, o_data=0. A further dequeue is ignored.
- Preload full heap, replace root with 5 -> after 25 cycles o_data = old 2nd largest, size stays 31, value 5 resides at a leaf-most valid position.
- Replace with a value larger than the root (e.g. 1025 with root 1024) -> o_data=1025, no swaps.
- 100 random dequeue/replace ops with values in 0..1024, 25 cycles apart -> o_data always equals the maximum of a software reference queue, or 0 when empty.
